// File: rtl/channel_gather.sv
// channel_gather: rebuilds a six-channel pixel from tagged bytes (valid/ready in, valid/ready out, drop pulse on timeout); define CHANNEL_GATHER_ERRCNT_EN for err_count_out
module channel_gather #(
  parameter logic [5:0] REQ_MASK = 6'b111111,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       valid_in,
  output logic       ready_out,
  input  logic [2:0] select_in,
  input  logic [7:0] data_in,
  output logic [7:0] r_out,
  output logic [7:0] g_out,
  output logic [7:0] b_out,
  output logic [7:0] y_out,
  output logic [7:0] cr_out,
  output logic [7:0] cb_out,
  output logic       valid_out,
  input  logic       ready_in,
  output logic       drop_out,
  output logic [7:0] err_count_out
);
  typedef enum logic {COLLECT, HOLD} state_e;
  localparam logic TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  state_e state_q;
  logic [5:0] got_q, hit, mask_d;
  logic [15:0] cnt_q;
  logic [7:0] ch_q [6];
  logic valid_q, drop_q, legal, acc, acc_legal, done, expire;
  always_comb begin
    hit = select_in == 3'b001 ? 6'b000001 :
          select_in == 3'b000 ? 6'b000010 :
          select_in == 3'b010 ? 6'b000100 :
          select_in == 3'b100 ? 6'b001000 :
          select_in == 3'b101 ? 6'b010000 :
          select_in == 3'b110 ? 6'b100000 : 6'b000000;
    legal = |hit;
    acc = valid_in && state_q == COLLECT;
    acc_legal = acc && legal;
    mask_d = got_q | (acc_legal ? hit : 6'b0);
    done = acc_legal && ((mask_d & REQ_MASK) == REQ_MASK);
    expire = TO_EN && state_q == COLLECT && |got_q && !acc_legal && cnt_q == TO_LAST;
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= COLLECT;
      got_q <= 6'b0;
      cnt_q <= 16'd0;
      valid_q <= 1'b0;
      drop_q <= 1'b0;
      for (int i = 0; i < 6; i++) ch_q[i] <= 8'd0;
    end else begin
      drop_q <= expire;
      for (int i = 0; i < 6; i++) if (acc_legal && hit[i]) ch_q[i] <= data_in;
      if (state_q == HOLD) begin
        if (ready_in) begin
          state_q <= COLLECT;
          valid_q <= 1'b0;
          got_q <= 6'b0;
          cnt_q <= 16'd0;
        end
      end else if (done) begin
        state_q <= HOLD;
        valid_q <= 1'b1;
        got_q <= mask_d;
        cnt_q <= 16'd0;
      end else if (expire) begin
        got_q <= 6'b0;
        cnt_q <= 16'd0;
      end else begin
        got_q <= mask_d;
        cnt_q <= (acc_legal || got_q == 6'b0 || !TO_EN) ? 16'd0 : cnt_q + 16'd1;
      end
    end
  end
  assign ready_out = state_q == COLLECT;
  assign valid_out = valid_q;
  assign drop_out = drop_q;
  assign r_out = ch_q[0];
  assign g_out = ch_q[1];
  assign b_out = ch_q[2];
  assign y_out = ch_q[3];
  assign cr_out = ch_q[4];
  assign cb_out = ch_q[5];
`ifdef CHANNEL_GATHER_ERRCNT_EN
  logic [7:0] err_q;
  logic err;
  assign err = acc && (!legal || |(got_q & hit));
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) err_q <= 8'd0;
    else err_q <= (err && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end
  assign err_count_out = err_q;
`else
  assign err_count_out = 8'd0;
`endif
endmodule

// File: tb/tb_channel_gather.sv
// tb_channel_gather: scoreboard bench for channel_gather
module tb_channel_gather;
  logic clk, rst_n, valid, ready_in, sub_valid;
  logic [2:0] sel;
  logic [7:0] data;
  logic ready_out, valid_out, drop_out;
  logic [7:0] r, g, b, y, cr, cb, err;
  logic s_ready, s_valid, s_drop;
  logic [7:0] sr, sg, sb, sy, scr, scb, serr;
  int compared = 0, mismatched = 0;
  logic [55:0] q [$];
  logic [23:0] sq [$];
`ifdef CHANNEL_GATHER_ERRCNT_EN
  localparam logic [7:0] EXP_ERR = 8'd2;
`else
  localparam logic [7:0] EXP_ERR = 8'd0;
`endif

  channel_gather #(.REQ_MASK(6'b111111), .TIMEOUT_CYCLES(8)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid), .ready_out(ready_out),
    .select_in(sel), .data_in(data), .r_out(r), .g_out(g), .b_out(b), .y_out(y),
    .cr_out(cr), .cb_out(cb), .valid_out(valid_out), .ready_in(ready_in),
    .drop_out(drop_out), .err_count_out(err));

  channel_gather #(.REQ_MASK(6'b000111), .TIMEOUT_CYCLES(0)) sub (
    .clk_in(clk), .rst_n_in(rst_n), .valid_in(sub_valid), .ready_out(s_ready),
    .select_in(sel), .data_in(data), .r_out(sr), .g_out(sg), .b_out(sb), .y_out(sy),
    .cr_out(scr), .cb_out(scb), .valid_out(s_valid), .ready_in(ready_in),
    .drop_out(s_drop), .err_count_out(serr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && valid_out && ready_in) begin
      if (q.size() == 0) chk("unexpected_pixel", {r, g, b, y, cr, cb, err}, 56'hx);
      else chk("pixel", {r, g, b, y, cr, cb, err}, q.pop_front());
    end
    if (rst_n && s_valid && ready_in) begin
      if (sq.size() == 0) chk("unexpected_sub_pixel", {sr, sg, sb}, 24'hx);
      else chk("sub_pixel", {sr, sg, sb}, sq.pop_front());
    end
  end

  task automatic send(input logic [2:0] s, input logic [7:0] d);
    valid = 1'b1; sel = s; data = d;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic send_sub(input logic [2:0] s, input logic [7:0] d);
    sub_valid = 1'b1; sel = s; data = d;
    @(posedge clk); #1;
    sub_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int pulses, at;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; valid = 1'b0; sub_valid = 1'b0; ready_in = 1'b1; sel = 3'd0; data = 8'd0;
    idle(2);
    chk("reset_outputs", {valid_out, ready_out, drop_out, r, cb, err}, {1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0});
    rst_n = 1'b1;
    idle(1);
    // full gather
    q.push_back({48'h112233445566, 8'd0});
    send(3'b001, 8'h11); send(3'b000, 8'h22); send(3'b010, 8'h33);
    send(3'b100, 8'h44); send(3'b101, 8'h55); send(3'b110, 8'h66);
    chk("hold_after_full", {valid_out, ready_out}, 2'b10);
    idle(1);
    chk("collect_after_handoff", {valid_out, ready_out}, 2'b01);
    // back-pressure
    ready_in = 1'b0;
    q.push_back({48'hA1A2A3A4A5A6, 8'd0});
    send(3'b001, 8'hA1); send(3'b000, 8'hA2); send(3'b010, 8'hA3);
    send(3'b100, 8'hA4); send(3'b101, 8'hA5); send(3'b110, 8'hA6);
    valid = 1'b1; sel = 3'b001; data = 8'hEE;
    for (int i = 0; i < 10; i++) begin
      chk("bp_stable", {valid_out, ready_out, r, g, b, y, cr, cb}, {2'b10, 48'hA1A2A3A4A5A6});
      idle(1);
    end
    valid = 1'b0; ready_in = 1'b1;
    idle(1);
    chk("bp_release", valid_out, 1'b0);
    // illegal and duplicate
    q.push_back({48'h200203040506, EXP_ERR});
    send(3'b011, 8'h99); send(3'b001, 8'h10); send(3'b001, 8'h20);
    send(3'b000, 8'h02); send(3'b010, 8'h03); send(3'b100, 8'h04);
    send(3'b101, 8'h05); send(3'b110, 8'h06);
    idle(1);
    // timeout after r, g
    send(3'b001, 8'h31); send(3'b000, 8'h32);
    pulses = 0; at = 0;
    for (int k = 1; k <= 12; k++) begin
      idle(1);
      if (drop_out) begin pulses++; at = k; end
    end
    chk("drop_pulses", pulses, 1);
    chk("drop_cycle", at, 8);
    q.push_back({48'h414243444546, EXP_ERR});
    send(3'b001, 8'h41); send(3'b000, 8'h42); send(3'b010, 8'h43);
    send(3'b100, 8'h44); send(3'b101, 8'h45);
    chk("no_early_after_drop", valid_out, 1'b0);
    send(3'b110, 8'h46);
    idle(1);
    // subset mask instance
    sq.push_back(24'h515253);
    send_sub(3'b001, 8'h51); send_sub(3'b000, 8'h52); send_sub(3'b010, 8'h53);
    chk("sub_valid_after_3", {s_valid, s_ready}, 2'b10);
    idle(1);
    // reset mid-gather
    send(3'b001, 8'h61); send(3'b000, 8'h62); send(3'b010, 8'h63);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {valid_out, ready_out, drop_out, r, g, err, sr}, {3'b010, 8'd0, 8'd0, 8'd0, 8'd0});
    @(negedge clk); rst_n = 1'b1;
    idle(1);
    q.push_back({48'h717273747576, 8'd0});
    send(3'b100, 8'h74); send(3'b101, 8'h75); send(3'b110, 8'h76);
    send(3'b001, 8'h71); send(3'b000, 8'h72);
    chk("fresh_after_reset", valid_out, 1'b0);
    send(3'b010, 8'h73);
    idle(2);
    chk("queues_drained", {q.size(), sq.size()}, 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
